riscv_stream_out_fifo: RTL and testbench
========================================

// Module: riscv_stream_out_fifo
// PURPOSE
//   Downstream of the PicoRV32 memory/MMIO stage. Captures each word the CPU stores to the stream-out
//   address (0x10000008), signalled by a one-cycle valid pulse. Buffers the words in a FIFO and
//   re-presents them on a standard valid/ready stream toward the stream fabric.
//   Decouples the CPU store stall from downstream backpressure. Counts and flags words lost to overflow.
// PARAMETERS
//   DWIDTH     32   data width of the stream word
//   ADDR_BITS  4    FIFO address width; DEPTH = 2**ADDR_BITS (default 16 entries)
//   CNT_WIDTH  16   width of the dropped-word counter
// PORTS
//   clk            in   1          single clock, all logic on rising edge
//   reset          in   1          asynchronous, active-high; clears all state
//   val_in         in   1          one-cycle pulse: din is valid this cycle (upstream val_out)
//   din            in   DWIDTH     word from CPU store data
//   ready_upward   out  1          FIFO not full; drives upstream ready_downward
//   val_out        out  1          downstream word valid
//   dout           out  DWIDTH     downstream word
//   ready_downward in   1          downstream accepts dout when val_out && ready_downward
//   level          out  ADDR_BITS+1  current occupancy, 0..DEPTH
//   overflow       out  1          sticky: a word was dropped
//   drop_cnt       out  CNT_WIDTH  dropped-word count, saturating
//   clr_ovf        in   1          synchronous clear of overflow and drop_cnt
// BEHAVIOUR
//   Reset values: ready_upward=1, val_out=0, dout=0, level=0, overflow=0, drop_cnt=0; rd/wr pointers=0.
//   Reset mid-operation: contents are discarded, no partial word is emitted, and val_out drops immediately.
//   push = val_in && (level<DEPTH || pop). pop = val_out && ready_downward.
//   ready_upward = (level != DEPTH). It is decoded from the registered level and has no combinational path
//     from ready_downward.
//   Storage: array of DEPTH x DWIDTH with ADDR_BITS-wide pointers that wrap naturally mod DEPTH.
//     A push writes mem[wr_ptr] and increments wr_ptr.
//   Output: registered first-word-fall-through.
//     A word pushed into an empty FIFO at cycle N appears at val_out=1 at cycle N+1.
//   Stability: dout/val_out hold stable while val_out && !ready_downward.
//   level: +1 on push only, -1 on pop only, unchanged on push&&pop. It never exceeds DEPTH and never goes below 0.
//   Full && val_in && !pop: the word is dropped. overflow<=1 and drop_cnt+=1, saturating at all-ones.
//     The FIFO contents are untouched.
//   Full && val_in && pop: the word is accepted, with no drop.
//   Empty && push && ready_downward: the word is not bypassed. It is emitted at N+1; there is no zero-cycle path.
//   clr_ovf coinciding with a drop: the drop wins, leaving overflow=1 and drop_cnt=1.
//   val_in while reset is asserted is ignored.
// STRUCTURE
//   Shared header stream_defs.vh holds:
//     MMIO addresses STREAM_OUT_ADDR=32'h10000008 and STREAM_IN_ADDR=32'h10000004;
//     the default FIFO ADDR_BITS.
//   One sub-module: stream_fifo_ram (simple dual-port, registered read, DEPTH x DWIDTH, RAM_TYPE "distributed").
//   Pointers, level, the output register and the drop counter stay in this module.
// TESTING
//   1) Reset, then one val_in pulse with din=32'hA5A5_0001 and ready_downward=1.
//      -> val_out=1 with dout=A5A5_0001 exactly one cycle later; level returns to 0.
//   2) Push 16 words 0..15 with ready_downward=0.
//      -> level=16, ready_upward=0; a 17th pulse sets overflow=1, drop_cnt=1, and words 0..15 drain in order.
//   3) Full FIFO, ready_downward=1 and val_in pulse in the same cycle.
//      -> no drop, level stays 16, and the new word emerges last.
//   4) Random val_in (~30%) and ready_downward (~50%) over 10k cycles.
//      -> scoreboard in-order match; level==model and never >16.
//   5) Stall with val_out=1, ready_downward=0 for 5 cycles.
//      -> dout unchanged; ready_downward=1 then pops exactly one word.
//   6) Assert reset with level=7 mid-stream.
//      -> val_out=0 and level=0 asynchronously; the next push is emitted as the first word after release.

Source files
------------

// File: rtl/riscv_stream_out_fifo_pkg.sv
// Shared constants for the CPU stream-out path: MMIO addresses, default FIFO
// geometry, and the occupancy update encoding used by the FIFO controller.
package riscv_stream_out_fifo_pkg;

    localparam logic [31:0] STREAM_OUT_ADDR = 32'h1000_0008;
    localparam logic [31:0] STREAM_IN_ADDR  = 32'h1000_0004;

    localparam int SOF_DWIDTH    = 32;
    localparam int SOF_ADDR_BITS = 4;
    localparam int SOF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port FIFO storage with a registered read port. A same-cycle write
// to the address being read is forwarded so the read register is never stale.
module stream_fifo_ram #(
    parameter int DWIDTH    = 32,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DWIDTH-1:0]    wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DWIDTH-1:0]    rdata_o
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    (* ram_style = "distributed" *) logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_stream_out_fifo.sv
// Buffers CPU stream-out stores and re-presents them as a valid/ready stream,
// with a sticky overflow flag and saturating count of words lost when full.
module riscv_stream_out_fifo
    import riscv_stream_out_fifo_pkg::*;
#(
    parameter int DWIDTH    = SOF_DWIDTH,
    parameter int ADDR_BITS = SOF_ADDR_BITS,
    parameter int CNT_WIDTH = SOF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 val_in,
    input  logic [DWIDTH-1:0]    din,
    output logic                 ready_upward,
    output logic                 val_out,
    output logic [DWIDTH-1:0]    dout,
    input  logic                 ready_downward,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    input  logic                 clr_ovf
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   FULL_LVL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   LVL_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d, cnt_base;
    logic                 full, push, pop, drop;
    lvl_op_e              lvl_op;

    // The head word always sits in the RAM read register, so occupancy alone
    // decides validity and val_out falls as soon as reset clears the level.
    assign full    = (level_q == FULL_LVL);
    assign val_out = (level_q != '0);
    assign pop     = val_out && ready_downward;
    assign push    = val_in && (!full || pop);
    assign drop    = val_in && full && !pop;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (push && !pop) begin
            lvl_op = LVL_INC;
        end else if (pop && !push) begin
            lvl_op = LVL_DEC;
        end

        case (lvl_op)
            LVL_INC: level_d = level_q + LVL_ONE;
            LVL_DEC: level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        // Clear applies first so a coincident drop leaves exactly one counted.
        cnt_base   = clr_ovf ? '0 : drop_cnt_q;
        overflow_d = clr_ovf ? 1'b0 : overflow_q;
        drop_cnt_d = cnt_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (cnt_base != '1) begin
                drop_cnt_d = cnt_base + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Reading at the next head pointer keeps the output register aligned with
    // the head; holding it when the FIFO will be empty keeps dout quiet.
    stream_fifo_ram #(
        .DWIDTH   (DWIDTH),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .rst    (reset),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(din),
        .re_i   (level_d != '0),
        .raddr_i(rd_ptr_d),
        .rdata_o(dout)
    );

    assign ready_upward = !full;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_riscv_stream_out_fifo.sv
// Scoreboard bench for riscv_stream_out_fifo: a queue model predicts accepted
// words, drops and occupancy; a monitor compares every transfer and status.
module tb_riscv_stream_out_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        val_in = 1'b0;
    logic [31:0] din = '0;
    logic        ready_upward;
    logic        val_out;
    logic [31:0] dout;
    logic        ready_downward = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;
    logic        pend_push = 1'b0, pend_drop = 1'b0, pend_clr = 1'b0;
    logic [31:0] pend_word = '0;

    riscv_stream_out_fifo dut (
        .clk(clk), .reset(reset), .val_in(val_in), .din(din),
        .ready_upward(ready_upward), .val_out(val_out), .dout(dout),
        .ready_downward(ready_downward), .level(level), .overflow(overflow),
        .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Commit last cycle's predicted effects once the clock edge has applied them.
    task automatic apply_pending();
        if (pend_push) exp_q.push_back(pend_word);
        if (pend_clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (pend_drop) begin
            m_ovf = 1'b1;
            if (m_cnt != 65535) m_cnt++;
        end
        pend_push = 1'b0;
        pend_drop = 1'b0;
        pend_clr  = 1'b0;
    endtask

    task automatic drive(input logic vin, input logic [31:0] d, input logic rdy, input logic clr);
        int sz;
        @(posedge clk);
        #1;
        apply_pending();
        sz = exp_q.size();
        val_in = vin;
        din = d;
        ready_downward = rdy;
        clr_ovf = clr;
        pend_push = vin && (sz < DEPTH || (sz > 0 && rdy));
        pend_drop = vin && (sz == DEPTH) && !rdy;
        pend_clr  = clr;
        pend_word = d;
        $display("txn vin=%0d din=%h rdy=%0d clr=%0d model_level=%0d", vin, d, rdy, clr, sz);
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the model.
    always @(negedge clk) begin
        logic [31:0] w;
        if (!reset) begin
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("val_out", 32'(val_out), 32'(exp_q.size() != 0));
            chk("ready_upward", 32'(ready_upward), 32'(exp_q.size() != DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
            if (val_out && ready_downward) begin
                if (exp_q.size() == 0) begin
                    chk("pop_when_model_empty", 32'(1), 32'(0));
                end else begin
                    w = exp_q.pop_front();
                    chk("dout_order", dout, w);
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        #3;
        chk("rst_val_out", 32'(val_out), 32'(0));
        chk("rst_ready_upward", 32'(ready_upward), 32'(1));
        chk("rst_dout", dout, 32'h0);
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1) single word, one-cycle latency
        drive(1, 32'hA5A5_0001, 1, 0);
        drive(0, 0, 1, 0);
        chk("t1_val_out", 32'(val_out), 32'(1));
        chk("t1_dout", dout, 32'hA5A5_0001);
        drive(0, 0, 1, 0);
        chk("t1_level_back_to_0", 32'(level), 32'(0));

        // 2) fill, overflow by one, drain in order
        for (int i = 0; i < 16; i++) drive(1, 32'(i), 0, 0);
        drive(1, 32'hDEAD_0099, 0, 0);
        chk("t2_level_full", 32'(level), 32'(16));
        chk("t2_ready_upward", 32'(ready_upward), 32'(0));
        drive(0, 0, 0, 0);
        chk("t2_overflow", 32'(overflow), 32'(1));
        chk("t2_drop_cnt", 32'(drop_cnt), 32'(1));
        for (int i = 0; i < 18; i++) drive(0, 0, 1, 0);
        chk("t2_drained", 32'(level), 32'(0));

        // clr coinciding with a drop leaves a count of one
        for (int i = 0; i < 16; i++) drive(1, 32'h2000 + 32'(i), 0, 0);
        drive(1, 32'hD0D0_0001, 0, 0);
        drive(1, 32'hD0D0_0002, 0, 1);
        drive(0, 0, 0, 0);
        chk("clr_drop_overflow", 32'(overflow), 32'(1));
        chk("clr_drop_cnt", 32'(drop_cnt), 32'(1));
        drive(0, 0, 0, 1);

        // 3) full + pop + push: accepted, emerges last
        drive(1, 32'h3333_0000, 1, 0);
        drive(0, 0, 0, 0);
        chk("t3_level_stays_full", 32'(level), 32'(16));
        chk("t3_no_drop", 32'(drop_cnt), 32'(0));
        for (int i = 0; i < 18; i++) drive(0, 0, 1, 0);

        // 5) stall holds dout, then exactly one pop
        for (int i = 0; i < 3; i++) drive(1, 32'h5500_0000 + 32'(i), 0, 0);
        drive(0, 0, 0, 0);
        held = dout;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            chk("t5_dout_stable", dout, held);
        end
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        chk("t5_one_pop", 32'(level), 32'(2));
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);

        // 4) random traffic
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 1);
            if (level > 5'd16) chk("t4_level_bound", 32'(level), 32'(16));
        end
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("t4_model_empty", 32'(exp_q.size()), 32'(0));

        // 6) async reset at level 7
        for (int i = 0; i < 7; i++) drive(1, 32'h6600_0000 + 32'(i), 0, 0);
        drive(0, 0, 0, 0);
        chk("t6_level_7", 32'(level), 32'(7));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_val_out", 32'(val_out), 32'(0));
        chk("t6_async_level", 32'(level), 32'(0));
        exp_q.delete();
        pend_push = 1'b0;
        pend_drop = 1'b0;
        pend_clr  = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        val_in = 1'b1;
        din = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        val_in = 1'b0;
        reset = 1'b0;
        chk("t6_ignored_during_reset", 32'(level), 32'(0));
        drive(1, 32'hBEEF_0001, 1, 0);
        drive(0, 0, 1, 0);
        chk("t6_first_after_reset", dout, 32'hBEEF_0001);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
